// File: rtl/ramr.sv
// ramr: byte-serial FIFO reader. Pops NBYTE bytes from the fifoe read port
// and packs them into one DW-bit word, first byte popped in the MSB byte.
// Frame handshake toward the controller is the level fs/fd pair.
module ramr #(
    parameter  int unsigned NBYTE = 12,
    localparam int unsigned DW    = 8 * NBYTE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fs,
    output logic          fd,
    input  logic          fifoe_empty,
    output logic          fifoe_rxen,
    input  logic [7:0]    fifoe_rxd,
    output logic [DW-1:0] data,
    output logic [7:0]    so
);

    typedef enum logic [7:0] {
        IDLE = 8'h00,
        READ = 8'h10,
        LAST = 8'h80
    } state_t;

    localparam logic [3:0] NB_CNT  = 4'(NBYTE);
    localparam logic [3:0] NB_LAST = 4'(NBYTE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] rd_cnt;
    logic [3:0] cap_cnt;
    logic       rxen_d;
    logic       start;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; unknown codes fall back to IDLE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = fs ? READ : IDLE;
            READ:    state_nxt = (rxen_d && (cap_cnt == NB_LAST)) ? LAST : READ;
            LAST:    state_nxt = fs ? LAST : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: pop only while reading, FIFO non-empty and frame not fully issued.
    always_comb begin
        start      = (state == IDLE) && fs;
        fifoe_rxen = (state == READ) && !fifoe_empty && (rd_cnt != NB_CNT);
        fd         = (state == LAST);
        so         = state;
    end

    // Pop/capture counters and the shift-in of read data (read latency 1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt  <= '0;
            cap_cnt <= '0;
            rxen_d  <= 1'b0;
            data    <= '0;
        end else begin
            rxen_d <= fifoe_rxen;
            if (start) begin
                rd_cnt  <= '0;
                cap_cnt <= '0;
                data    <= '0;
            end else begin
                if (fifoe_rxen) begin
                    rd_cnt <= rd_cnt + 4'd1;
                end
                if (rxen_d) begin
                    data    <= DW'({data, fifoe_rxd});
                    cap_cnt <= cap_cnt + 4'd1;
                end
            end
        end
    end

endmodule
